// File: rtl/index_pkg.sv
// rtl/index_pkg.sv - shared types and sizes for the index loader and compare engine
package index_pkg;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ORDER = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;

endpackage

// File: rtl/index_loader_if.sv
// rtl/index_loader_if.sv - input word stream and RAM write port of the index loader
interface index_loader_if #(
    parameter int DW = 8,
    parameter int AW = 4
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    logic          wr_en1;
    logic          wr_en2;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  wr_en1, wr_en2, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output wr_en1, wr_en2, wr_addr, wr_data
    );

endinterface

// File: rtl/asc_check.sv
// rtl/asc_check.sv - strict-ascending check against the previous word of the current list
module asc_check #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          update_i,
    input  logic [DW-1:0] data_i,
    output logic          order_ok_o
);

    logic [DW-1:0] prev_q;
    logic          first_q;

    // clear wins over update so the last word of a list cannot seed the next one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= '0;
            first_q <= 1'b1;
        end else if (clear_i) begin
            first_q <= 1'b1;
        end else if (update_i) begin
            prev_q  <= data_i;
            first_q <= 1'b0;
        end
    end

    assign order_ok_o = first_q | (data_i > prev_q);

endmodule

// File: rtl/index_loader.sv
// rtl/index_loader.sv - fills the two index RAMs from lists A and B, reports lengths and errors
module index_loader
    import index_pkg::*;
#(
    parameter int DW    = index_pkg::DW,
    parameter int DEPTH = index_pkg::DEPTH,
    parameter int AW    = index_pkg::AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    index_loader_if.slave bus,
    output logic [AW:0]   len1_o,
    output logic [AW:0]   len2_o,
    output logic          done_o,
    output logic [1:0]    error_o
);

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic          in_ready_q;
    logic          wr_en1_q;
    logic          wr_en2_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [AW:0]   len1_q;
    logic [AW:0]   len2_q;
    logic          done_q;
    logic [1:0]    error_q;

    logic          accept;
    logic          list_b;
    logic          start_ok;
    logic          at_end;
    logic          order_ok;
    logic          asc_clear;
    logic [AW:0]   len_d;

    // in_ready_q is only ever set in the load states, so it doubles as the load qualifier
    assign accept    = bus.in_valid & in_ready_q;
    assign list_b    = (state_q == S_LOAD_B);
    assign start_ok  = start_i & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
    assign at_end    = (addr_q == AW'(DEPTH - 1));
    assign len_d     = {1'b0, addr_q} + (AW + 1)'(1);
    assign asc_clear = start_ok | (accept & order_ok & bus.in_last & ~list_b);

    asc_check #(.DW(DW)) u_asc_check (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (asc_clear),
        .update_i   (accept & order_ok),
        .data_i     (bus.in_data),
        .order_ok_o (order_ok)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en1_q   <= 1'b0;
            wr_en2_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            len1_q     <= '0;
            len2_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= ERR_NONE;
        end else begin
            wr_en1_q <= 1'b0;
            wr_en2_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (state_q == S_IDLE) begin
                        addr_q  <= '0;
                        len1_q  <= '0;
                        len2_q  <= '0;
                        done_q  <= 1'b0;
                        error_q <= ERR_NONE;
                    end
                    if (start_i) begin
                        state_q    <= S_LOAD_A;
                        in_ready_q <= 1'b1;
                        addr_q     <= '0;
                        len1_q     <= '0;
                        len2_q     <= '0;
                        done_q     <= 1'b0;
                        error_q    <= ERR_NONE;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (accept) begin
                        if (!order_ok) begin
                            error_q    <= ERR_ORDER;
                            in_ready_q <= 1'b0;
                            state_q    <= S_ERR;
                        end else begin
                            wr_en1_q  <= ~list_b;
                            wr_en2_q  <= list_b;
                            wr_addr_q <= addr_q;
                            wr_data_q <= bus.in_data;
                            if (bus.in_last) begin
                                addr_q <= '0;
                                if (list_b) begin
                                    len2_q     <= len_d;
                                    done_q     <= 1'b1;
                                    in_ready_q <= 1'b0;
                                    state_q    <= S_DONE;
                                end else begin
                                    len1_q  <= len_d;
                                    state_q <= S_LOAD_B;
                                end
                            end else if (at_end) begin
                                // the word at the last address is kept, the list is not
                                error_q    <= ERR_OVF;
                                in_ready_q <= 1'b0;
                                state_q    <= S_ERR;
                            end else begin
                                addr_q <= addr_q + AW'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en1   = wr_en1_q;
    assign bus.wr_en2   = wr_en2_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign len1_o       = len1_q;
    assign len2_o       = len2_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_index_loader.sv
// tb/tb_index_loader.sv - directed scoreboard bench for index_loader
module tb_index_loader;
    import index_pkg::*;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len1;
    logic [AW:0]   len2;
    logic          done;
    logic [1:0]    error;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [13:0]   exp_q[$];

    index_loader_if #(.DW(DW), .AW(AW)) bus ();

    index_loader #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .bus     (bus),
        .len1_o  (len1),
        .len2_o  (len2),
        .done_o  (done),
        .error_o (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected write word: {wr_en1, wr_en2, wr_addr, wr_data}
    always @(negedge clk) begin
        if (bus.wr_en1 || bus.wr_en2) begin
            if (exp_q.size() == 0)
                check("unexpected_write", {18'd0, bus.wr_en1, bus.wr_en2, bus.wr_addr, bus.wr_data}, 32'd0);
            else
                check("write", {18'd0, bus.wr_en1, bus.wr_en2, bus.wr_addr, bus.wr_data},
                      {18'd0, exp_q.pop_front()});
        end
    end

    task automatic put(input logic [7:0] d, input bit l, input bit wr, input bit b, input logic [3:0] a);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", {31'd0, bus.in_ready}, 32'd1);
        if (wr) exp_q.push_back({~b, b, a, d});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", {31'd0, bus.in_ready}, 32'd1);
        check("start_clear", {24'd0, len1, len2, done, error}, 32'd0);
    endtask

    task automatic check_end(input logic [4:0] l1, input logic [4:0] l2, input logic d, input logic [1:0] e);
        check("len1", {27'd0, len1}, {27'd0, l1});
        check("len2", {27'd0, len2}, {27'd0, l2});
        check("done", {31'd0, done}, {31'd0, d});
        check("error", {30'd0, error}, {30'd0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {13'd0, bus.in_ready, bus.wr_en1, bus.wr_en2, bus.wr_addr, bus.wr_data}, 32'd0);
        check_end(5'd0, 5'd0, 1'b0, ERR_NONE);
        rst_n = 1'b1;
        idle(2);

        // A={3,7,9,20}, B={1,7}, valid held high
        pulse_start();
        put(8'd3, 0, 1, 0, 4'd0);
        put(8'd7, 0, 1, 0, 4'd1);
        put(8'd9, 0, 1, 0, 4'd2);
        put(8'd20, 1, 1, 0, 4'd3);
        check("len1_early", {27'd0, len1}, 32'd4);
        put(8'd1, 0, 1, 1, 4'd0);
        put(8'd7, 1, 1, 1, 4'd1);
        check_end(5'd4, 5'd2, 1'b1, ERR_NONE);
        check("done_ready", {31'd0, bus.in_ready}, 32'd0);
        idle(2);
        check("done_held", {31'd0, done}, 32'd1);

        // full-depth lists
        pulse_start();
        for (int i = 0; i < 16; i++) put(8'(i), i == 15, 1, 0, 4'(i));
        check("len1_full", {27'd0, len1}, 32'd16);
        for (int i = 0; i < 16; i++) put(8'(i), i == 15, 1, 1, 4'(i));
        check_end(5'd16, 5'd16, 1'b1, ERR_NONE);
        idle(1);

        // repeated value
        pulse_start();
        put(8'd5, 0, 1, 0, 4'd0);
        put(8'd5, 0, 0, 0, 4'd0);
        check_end(5'd0, 5'd0, 1'b0, ERR_ORDER);
        check("order_ready", {31'd0, bus.in_ready}, 32'd0);
        idle(2);
        check("order_held", {30'd0, error}, {30'd0, ERR_ORDER});
        pulse_start();
        put(8'd2, 1, 1, 0, 4'd0);
        put(8'd9, 1, 1, 1, 4'd0);
        check_end(5'd1, 5'd1, 1'b1, ERR_NONE);
        idle(1);

        // overflow: 16 words without last, 17th offered but refused
        pulse_start();
        for (int i = 0; i < 16; i++) put(8'(2 * i), 0, 1, 0, 4'(i));
        check_end(5'd0, 5'd0, 1'b0, ERR_OVF);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        repeat (3) begin
            check("ovf_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        idle(1);

        // reset in the middle of list B
        pulse_start();
        put(8'd10, 0, 1, 0, 4'd0);
        put(8'd20, 1, 1, 0, 4'd1);
        put(8'd2, 0, 1, 1, 4'd0);
        put(8'd4, 0, 1, 1, 4'd1);
        put(8'd6, 0, 1, 1, 4'd2);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {13'd0, bus.in_ready, bus.wr_en1, bus.wr_en2, bus.wr_addr, bus.wr_data}, 32'd0);
        check_end(5'd0, 5'd0, 1'b0, ERR_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        pulse_start();
        put(8'd50, 1, 1, 0, 4'd0);
        put(8'd60, 1, 1, 1, 4'd0);
        check_end(5'd1, 5'd1, 1'b1, ERR_NONE);
        idle(1);

        // valid toggling on alternate cycles
        pulse_start();
        put(8'd1, 0, 1, 0, 4'd0);
        idle(1);
        put(8'd2, 0, 1, 0, 4'd1);
        idle(1);
        put(8'd3, 1, 1, 0, 4'd2);
        idle(1);
        put(8'd4, 1, 1, 1, 4'd0);
        check_end(5'd3, 5'd1, 1'b1, ERR_NONE);

        idle(3);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
